// File: rtl/add_arbiter_pkg.sv
// Shared widths and slot-state encoding for the round-robin shared-adder arbiter.
package add_arb_pkg;
    localparam int ADD_W    = 32;
    localparam int NREQ_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/add_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the shared adder.
interface add_arbiter_if
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = ADD_W,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_signed;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic              res_ovf;
    logic [IDW-1:0]    res_id;

    modport master (
        output req_valid, req_a, req_b, req_signed, res_ready,
        input  req_ready, res_valid, res_sum, res_carry, res_ovf, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, res_ready,
        output req_ready, res_valid, res_sum, res_carry, res_ovf, res_id
    );
endinterface

// File: rtl/add_arbiter_rr_arbiter.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_grant
);
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (en && !any_grant && req[j]) begin
                grant[j]  = 1'b1;
                idx       = IW'(j);
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_arbiter.sv
// Shares one W-bit adder among NREQ requesters; results land in a single
// registered slot (sum, carry, signed overflow, requester id) drained by valid/ready.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = ADD_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic         clk,
    input logic         rst,
    add_arbiter_if.slave bus
);
    logic [NREQ-1:0][W-1:0] a_arr, b_arr;
    slot_state_t            state, state_nxt;
    logic [IDW-1:0]         rr_ptr, gnt_idx;
    logic [NREQ-1:0]        gnt;
    logic                   any_gnt, slot_free;
    logic [W-1:0]           op_a, op_b;
    logic [W:0]             add_full;
    logic                   add_ovf;
    logic [W-1:0]           sum_q;
    logic                   carry_q, ovf_q;
    logic [IDW-1:0]         id_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*W +: W];
        assign b_arr[g] = bus.req_b[g*W +: W];
    end

    // A full slot being drained this cycle can be refilled on the same edge.
    assign slot_free = (state == EMPTY) || bus.res_ready;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .en        (slot_free && !rst),
        .grant     (gnt),
        .idx       (gnt_idx),
        .any_grant (any_gnt)
    );

    assign bus.req_ready = gnt;

    assign op_a     = a_arr[gnt_idx];
    assign op_b     = b_arr[gnt_idx];
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign add_ovf  = bus.req_signed[gnt_idx] & (op_a[W-1] == op_b[W-1]) &
                      (add_full[W-1] != op_a[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (any_gnt) state_nxt = FULL;
            FULL:    if (bus.res_ready && !any_gnt) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Result fields and pointer move only on a grant; they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
            rr_ptr  <= '0;
        end else if (any_gnt) begin
            sum_q   <= add_full[W-1:0];
            carry_q <= add_full[W];
            ovf_q   <= add_ovf;
            id_q    <= gnt_idx;
            rr_ptr  <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_carry = carry_q;
    assign bus.res_ovf   = ovf_q;
    assign bus.res_id    = id_q;
endmodule

// File: tb/tb_add_arbiter.sv
// Randomized scoreboard bench for add_arbiter with directed corner scenarios.
module tb_add_arbiter;
    import add_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
    add_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t exp_q[$];
    int   rd_idx = 0;
    int   nvec   = 0;
    int   nfail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sgn, input int id);
        exp_t   e;
        longint us, ss;
        us      = longint'(a) + longint'(b);
        ss      = longint'($signed(a)) + longint'($signed(b));
        e.sum   = us[W-1:0];
        e.carry = (us > 64'sd4294967295);
        e.ovf   = sgn && (ss > SMAX || ss < SMIN);
        e.id    = id;
        return e;
    endfunction

    // Predictor: one time unit before each rising edge, decide who wins that edge.
    initial begin
        int              m_ptr, g;
        bit              m_full, free;
        logic [NREQ-1:0] expr;
        m_ptr  = 0;
        m_full = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                m_ptr  = 0;
                m_full = 0;
            end else begin
                free = !m_full || bus.res_ready;
                g    = -1;
                if (free)
                    for (int k = 0; k < NREQ; k++)
                        if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                expr = '0;
                if (g >= 0) expr[g] = 1'b1;
                check("req_ready", bus.req_ready, expr);
                if (g >= 0) begin
                    exp_q.push_back(ref_add(bus.req_a[g*W +: W], bus.req_b[g*W +: W],
                                            bus.req_signed[g], g));
                    m_ptr  = (g + 1) % NREQ;
                    m_full = 1;
                end else if (bus.res_ready) begin
                    m_full = 0;
                end
            end
        end
    end

    // Monitor: compare the presented slot against the oldest unconsumed expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_idx = exp_q.size();
                check("res_valid_in_rst", bus.res_valid, 0);
            end else begin
                check("res_valid", bus.res_valid, rd_idx < exp_q.size());
                if (bus.res_valid && rd_idx < exp_q.size()) begin
                    e = exp_q[rd_idx];
                    check("res_sum", bus.res_sum, e.sum);
                    check("res_carry", bus.res_carry, e.carry);
                    check("res_ovf", bus.res_ovf, e.ovf);
                    check("res_id", bus.res_id, e.id);
                    if (bus.res_ready) rd_idx++;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_signed[i]   = s;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
        bus.res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_sum", bus.res_sum, 0);
        check("rst_res_carry", bus.res_carry, 0);
        check("rst_res_ovf", bus.res_ovf, 0);
        check("rst_res_id", bus.res_id, 0);
        bus.req_valid = '0;
        @(negedge clk); #2; rst = 1'b0;

        // Unsigned wrap: carry out, no overflow.
        @(posedge clk); #1;
        set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b1;
        #1 check("t1_req_ready", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #1;
        check("t1_valid", bus.res_valid, 1);
        check("t1_sum", bus.res_sum, 0);
        check("t1_carry", bus.res_carry, 1);
        check("t1_ovf", bus.res_ovf, 0);
        check("t1_id", bus.res_id, 2);

        // Signed overflow, then same operands unsigned.
        @(posedge clk); #1;
        set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b1);
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus.req_signed[0] = 1'b0;
        #1;
        check("t2s_sum", bus.res_sum, 32'h8000_0000);
        check("t2s_ovf", bus.res_ovf, 1);
        check("t2s_carry", bus.res_carry, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #1;
        check("t2u_sum", bus.res_sum, 32'h8000_0000);
        check("t2u_ovf", bus.res_ovf, 0);

        // Fresh pointer, all requesters hold valid: grants rotate 0,1,2,3,0,1.
        @(negedge clk); #2; rst = 1'b1;
        @(negedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom));
        bus.req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            check("t3_id", bus.res_id, k % NREQ);
            check("t3_valid", bus.res_valid, 1);
        end

        // Stall three cycles with requests pending, then release.
        bus.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check("t4_req_ready", bus.req_ready, 0);
            check("t4_id_hold", bus.res_id, 1);
        end
        bus.res_ready = 1'b1;
        #1 check("t4_release_ready", bus.req_ready, 4'b0100);
        @(posedge clk); #2;
        check("t4_next_id", bus.res_id, 2);

        // Asynchronous reset while the slot is full.
        bus.res_ready = 1'b0;
        @(negedge clk); #2; rst = 1'b1;
        #1;
        check("t5_valid_drop", bus.res_valid, 0);
        check("t5_ready_in_rst", bus.req_ready, 0);
        @(negedge clk); #2; rst = 1'b0;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1010;
        #1 check("t5_first_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #2;
        check("t5_id", bus.res_id, 1);

        // Randomized traffic with backpressure.
        repeat (1500) begin
            @(posedge clk); #1;
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, pick_operand(), pick_operand(), 1'($urandom));
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("drain_all_consumed", rd_idx, exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
